// File: rtl/anc_pkg.sv
// anc_pkg: shared ANC constants, FSM state type and coefficient limits
package anc_pkg;
    localparam int NTAPS        = 120;
    localparam int ADDR_W       = 7;
    localparam int COEF_W       = 11;
    localparam int DATA_W       = 16;
    localparam int MU_SHIFT_DEF = 8;

    localparam logic signed [COEF_W-1:0] COEF_MAX = 11'sh3FF;
    localparam logic signed [COEF_W-1:0] COEF_MIN = 11'sh400;

    typedef enum logic [2:0] {IDLE, RD, WT, WR, CLR, DONE} state_t;
endpackage

// File: rtl/anc_lms_sat_update.sv
// anc_lms_sat_update: combinational LMS step W + ((e*x) >>> MU_SHIFT), saturated to COEF_W bits
//   w, e, x : signed coefficient, error and reference sample
//   w_new   : saturated updated coefficient
module anc_lms_sat_update
    import anc_pkg::*;
#(
    parameter int MU_SHIFT = MU_SHIFT_DEF
) (
    input  logic signed [COEF_W-1:0] w,
    input  logic signed [COEF_W-1:0] e,
    input  logic signed [COEF_W-1:0] x,
    output logic signed [COEF_W-1:0] w_new
);
    logic signed [2*COEF_W-1:0] p;
    logic signed [2*COEF_W:0]   s;

    always_comb begin
        p     = (2*COEF_W)'(e) * (2*COEF_W)'(x);
        s     = (2*COEF_W+1)'(w) + (2*COEF_W+1)'(p >>> MU_SHIFT);
        w_new = s > (2*COEF_W+1)'(COEF_MAX) ? COEF_MAX :
                s < (2*COEF_W+1)'(COEF_MIN) ? COEF_MIN : s[COEF_W-1:0];
    end
endmodule

// File: rtl/anc_coef_update_ctrl.sv
// anc_coef_update_ctrl: sequences one LMS update pass (or a zeroing pass) over the coefficient RAM
//   Clk_100M, Reset          : clock, synchronous active-high reset
//   Start_In, Clear_In       : pass requests from the sample scheduler (Clear wins)
//   Err_In                   : error sample latched on an accepted Start_In
//   X_Addr / X_In            : reference-history read port (1-cycle latency)
//   Ram_En/We/Addr/Din/Dout  : single-port coefficient RAM (1-cycle read latency)
//   Busy, Done               : pass in progress, one-cycle end-of-pass pulse
module anc_coef_update_ctrl
    import anc_pkg::*;
#(
    parameter int MU_SHIFT = MU_SHIFT_DEF
) (
    input  logic                     Clk_100M,
    input  logic                     Reset,
    input  logic                     Start_In,
    input  logic                     Clear_In,
    input  logic signed [COEF_W-1:0] Err_In,
    input  logic signed [COEF_W-1:0] X_In,
    output logic [ADDR_W-1:0]        X_Addr,
    output logic                     Ram_En,
    output logic                     Ram_We,
    output logic [ADDR_W-1:0]        Ram_Addr,
    output logic [DATA_W-1:0]        Ram_Din,
    input  logic [DATA_W-1:0]        Ram_Dout,
    output logic                     Busy,
    output logic                     Done
);
    state_t                   state;
    logic [ADDR_W-1:0]        k;
    logic signed [COEF_W-1:0] err;
    logic signed [COEF_W-1:0] w_new;
    logic                     last;
    logic                     unused_dout;

    assign last        = k == ADDR_W'(NTAPS - 1);
    assign unused_dout = ^Ram_Dout[DATA_W-1:COEF_W];

    // Ram_Dout and X_In are both valid during WT, so the result is registered straight into Ram_Din
    anc_lms_sat_update #(.MU_SHIFT(MU_SHIFT)) u_upd (
        .w     (Ram_Dout[COEF_W-1:0]),
        .e     (err),
        .x     (X_In),
        .w_new (w_new)
    );

    // Outputs are registered, so each branch drives the values for the state being entered
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state    <= IDLE;
            k        <= '0;
            err      <= '0;
            X_Addr   <= '0;
            Ram_En   <= 1'b0;
            Ram_We   <= 1'b0;
            Ram_Addr <= '0;
            Ram_Din  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Ram_En <= 1'b0;
            Ram_We <= 1'b0;
            Done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Clear_In) begin
                        state    <= CLR;
                        k        <= '0;
                        Ram_En   <= 1'b1;
                        Ram_We   <= 1'b1;
                        Ram_Addr <= '0;
                        Ram_Din  <= '0;
                        Busy     <= 1'b1;
                    end else if (Start_In) begin
                        state    <= RD;
                        k        <= '0;
                        err      <= Err_In;
                        Ram_En   <= 1'b1;
                        Ram_Addr <= '0;
                        X_Addr   <= '0;
                        Busy     <= 1'b1;
                    end
                end
                RD: state <= WT;
                WT: begin
                    state   <= WR;
                    Ram_En  <= 1'b1;
                    Ram_We  <= 1'b1;
                    Ram_Din <= {{(DATA_W-COEF_W){1'b0}}, w_new};
                end
                WR: begin
                    if (last) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else begin
                        state    <= RD;
                        k        <= k + 1'b1;
                        Ram_En   <= 1'b1;
                        Ram_Addr <= k + 1'b1;
                        X_Addr   <= k + 1'b1;
                    end
                end
                CLR: begin
                    if (last) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else begin
                        k        <= k + 1'b1;
                        Ram_En   <= 1'b1;
                        Ram_We   <= 1'b1;
                        Ram_Addr <= k + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/anc_coef_update_ctrl.md
Name: anc_coef_update_ctrl

Overview:
- Sequences one LMS coefficient-update pass over the 120-tap ANC coefficient block RAM (single-port, 16-bit words, 1-cycle read latency) after each filter sample.
- Per tap: reads W[k], fetches reference sample x[k] from the history buffer, computes W[k] + ((e·x[k]) >>> MU_SHIFT) with 11-bit saturation, and writes the result back.
- Also provides a clear pass that zeroes every coefficient.
- Sits between the top-level sample scheduler (which drives Start_In and Clear_In) and the coefficient RAM / reference-history RAM.

Parameters:
- NTAPS, 120, number of coefficients; valid addresses are 0..NTAPS-1.
- ADDR_W, 7, RAM address width.
- COEF_W, 11, signed coefficient, error and sample width.
- DATA_W, 16, RAM word width; a coefficient occupies bits [COEF_W-1:0] and the upper bits are written as 0.
- MU_SHIFT, 8, step size; the product is arithmetically right-shifted by this amount.

Ports:
- Clk_100M  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start_In  in  1  one-cycle request to start an update pass; honoured only in IDLE.
- Clear_In  in  1  one-cycle request to start a zeroing pass; honoured only in IDLE; wins over Start_In.
- Err_In  in  COEF_W  signed error sample; captured on the accepted Start_In.
- X_In  in  COEF_W  signed reference sample; valid 1 cycle after X_Addr is presented.
- X_Addr  out  ADDR_W  history-buffer read address.
- Ram_En  out  1  coefficient RAM enable.
- Ram_We  out  1  coefficient RAM write enable.
- Ram_Addr  out  ADDR_W  coefficient RAM address.
- Ram_Din  out  DATA_W  coefficient RAM write data.
- Ram_Dout  in  DATA_W  coefficient RAM read data; valid 1 cycle after a read.
- Busy  out  1  high while any pass is in progress.
- Done  out  1  one-cycle pulse when a pass finishes.

Behaviour:
- All outputs are registered. Reset forces every output to 0, the state to IDLE and the tap counter to 0.
- States: IDLE, RD, WT, WR, CLR, DONE.
- IDLE:
  - Clear_In=1: go to CLR with k=0.
  - Otherwise Start_In=1: latch Err_In, set k=0, go to RD.
  - Start_In or Clear_In in any other state is ignored; nothing is queued.
- RD: Ram_En=1, Ram_We=0, Ram_Addr=k, X_Addr=k. Go to WT.
- WT: register Ram_Dout[COEF_W-1:0] as signed W and X_In as signed x. Go to WR.
- WR:
  - Ram_En=1, Ram_We=1, Ram_Addr=k, Ram_Din={0, sat(W + ((e·x) >>> MU_SHIFT))}.
  - If k==NTAPS-1 go to DONE; otherwise k+1 and go to RD.
- Arithmetic:
  - The product e·x is full precision, 2·COEF_W bits, signed.
  - The shift is arithmetic, so it floors toward minus infinity.
  - The sum is sign-extended to 2·COEF_W+1 bits.
  - Saturation limits are +1023 and -1024 at COEF_W=11.
- CLR:
  - Ram_En=1, Ram_We=1, Ram_Addr=k, Ram_Din=0 each cycle.
  - When k==NTAPS-1 go to DONE; otherwise k+1.
  - Addresses NTAPS..2^ADDR_W-1 are never driven, in either pass.
- DONE: Done=1 for this cycle only. Go to IDLE.
- Busy is high in every state except IDLE.
  - Update pass: Busy is high for 3·NTAPS+1 = 361 cycles.
  - Clear pass: Busy is high for NTAPS+1 = 121 cycles.
- Ram_En and Ram_We are 0 in IDLE and DONE; X_Addr holds its last value.
- Reset asserted mid-pass:
  - Next state is IDLE, with Ram_We=0 from the next edge.
  - No Done pulse.
  - Coefficients already written stay written; the partial pass is not rolled back.
- Err_In changing during a pass has no effect.

Decomposition:
- Shared package anc_pkg holds:
  - Constants: NTAPS, COEF_W, DATA_W, ADDR_W and the default MU_SHIFT.
  - A state enum for IDLE/RD/WT/WR/CLR/DONE.
  - COEF_MAX and COEF_MIN.
- One natural sub-module, anc_lms_sat_update: purely combinational, taking (W, e, x) and producing the saturated W_new. It is reused by the secondary-path estimator.

Test Plan:
- Reset mid-pass: Start, then assert Reset at tap 50 in WR -> Ram_We=0 on the next edge, state IDLE, Busy=0, no Done; tap 50 is either fully written or untouched, and taps 51..119 are unchanged.
- Nominal update: W[3]=100, Err_In=64, x[3]=512 -> WR for tap 3 writes Ram_Din=16'd228. Done arrives 361 cycles after the Start edge, and exactly 120 writes occur, to addresses 0..119.
- Positive saturation: W=1000, e=1023, x=1023 -> (1046529>>>8)=4088, sum 5088 -> Ram_Din=16'h03FF.
- Negative saturation and floor:
  - W=-1000, e=1023, x=-1024 -> -4092, sum -5092 -> Ram_Din=16'h0400.
  - W=0, e=1, x=-1 -> Ram_Din=16'h07FF, which is -1.
- Clear with simultaneous Start: Clear_In=Start_In=1 in IDLE -> 120 consecutive zero writes, addresses 0..119, no reads. Done arrives after 121 cycles and a readback of the RAM is all zero.
- Ignored requests: Start_In pulsed at cycles 10 and 200 of an active pass -> no restart, Err_In is not re-latched, and exactly one Done.
